axil_reg_responder: RTL and testbench

AXIL_REG_RESPONDER -- requirements
Module: axil_reg_responder

---
 rtl/axil_reg_responder.sv | 197 +++++++++++++++++++
 tb/tb_axil_reg_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : axil_reg_responder
// Description : AXI4-Lite slave with four RW scratch words, a write counter
//               and an ID word. Define AXIL_REG_RESPONDER_SLVERR_EN to answer
//               unmapped words 6-7 with SLVERR instead of OKAY.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_reg_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_ID_VALUE = 32'h0000_0100
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_RESPONDER_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  logic [0:0]    w_state;
  logic [0:0]    r_state;
  logic          aw_held;
  logic          w_held;
  logic [2:0]    aw_word;
  logic [DW-1:0] wdata_held;
  logic [SW-1:0] wstrb_held;
  logic [DW-1:0] scratch [0:3];
  logic [DW-1:0] wr_count;

  logic          aw_hs;
  logic          w_hs;
  logic          aw_have;
  logic          w_have;
  logic          do_commit;
  logic [2:0]    commit_word;
  logic [DW-1:0] commit_data;
  logic [SW-1:0] commit_strb;
  logic [2:0]    rd_word;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_resp;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // A channel that handshakes this edge counts as already held.
  assign aw_hs       = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs        = S_AXI_WVALID & S_AXI_WREADY;
  assign aw_have     = aw_held | aw_hs;
  assign w_have      = w_held | w_hs;
  assign do_commit   = (w_state == W_IDLE) & aw_have & w_have;
  assign commit_word = aw_hs ? S_AXI_AWADDR[4:2] : aw_word;
  assign commit_data = w_hs ? S_AXI_WDATA : wdata_held;
  assign commit_strb = w_hs ? S_AXI_WSTRB : wstrb_held;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state       <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_word       <= '0;
      wdata_held    <= '0;
      wstrb_held    <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (do_commit) begin
            w_state       <= W_RESP;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b1;
            S_AXI_BRESP   <= (commit_word[2:1] == 2'b11) ? RESP_UNMAPPED : RESP_OKAY;
          end else begin
            aw_held       <= aw_have;
            w_held        <= w_have;
            S_AXI_AWREADY <= ~aw_have;
            S_AXI_WREADY  <= ~w_have;
            if (aw_hs) aw_word <= S_AXI_AWADDR[4:2];
            if (w_hs) begin
              wdata_held <= S_AXI_WDATA;
              wstrb_held <= S_AXI_WSTRB;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            w_state       <= W_IDLE;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Only scratch words count; ID, counter and unmapped writes are dropped.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < 4; i++) scratch[i] <= '0;
      wr_count <= '0;
    end else if (do_commit && !commit_word[2]) begin
      for (int b = 0; b < SW; b++) begin
        if (commit_strb[b]) scratch[commit_word[1:0]][8*b +: 8] <= commit_data[8*b +: 8];
      end
      wr_count <= wr_count + 1'b1;
    end
  end

  assign rd_word = S_AXI_ARADDR[4:2];
  assign rd_resp = (rd_word[2:1] == 2'b11) ? RESP_UNMAPPED : RESP_OKAY;

  always_comb begin
    rd_data = '0;
    case (rd_word)
      3'd0, 3'd1, 3'd2, 3'd3: rd_data = scratch[rd_word[1:0]];
      3'd4:                   rd_data = wr_count;
      3'd5:                   rd_data = C_ID_VALUE;
      default:                rd_data = '0;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            r_state       <= R_RESP;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= rd_data;
            S_AXI_RRESP   <= rd_resp;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b1;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_responder.sv
`default_nettype none
// Directed self-checking bench for axil_reg_responder.
module tb_axil_reg_responder;

`ifdef AXIL_REG_RESPONDER_SLVERR_EN
  localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int tests = 0;
  int fails = 0;

  axil_reg_responder dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic axi_write(input string tag, input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] exp_resp);
    int n;
    bit aw_hs, w_hs;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge ACLK); n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge ACLK); n++; end
    check({tag, ".bvalid"}, {31'd0, bvalid}, 32'd1);
    check({tag, ".bresp"}, {30'd0, bresp}, {30'd0, exp_resp});
    bready = 1'b1;
    @(negedge ACLK);
    bready = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [4:0] a, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    int n;
    bit hs;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      hs = arvalid && arready;
      @(negedge ACLK); n++;
      if (hs) arvalid = 1'b0;
    end
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge ACLK); n++; end
    check({tag, ".rdata"}, rdata, exp_data);
    check({tag, ".rresp"}, {30'd0, rresp}, {30'd0, exp_resp});
    rready = 1'b1;
    @(negedge ACLK);
    rready = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1;
    awaddr = '0; awprot = 3'b000; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;
    repeat (2) @(negedge ACLK);

    // Reset state
    check("rst.awready", {31'd0, awready}, 32'd0);
    check("rst.arready", {31'd0, arready}, 32'd0);
    check("rst.bvalid",  {31'd0, bvalid},  32'd0);
    check("rst.rvalid",  {31'd0, rvalid},  32'd0);
    check("rst.rdata",   rdata,            32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("rel.ready", {29'd0, awready, wready, arready}, 32'd7);

    // Basic scratch write/read and counter
    axi_write("w0", 5'h00, 32'd1, 4'hF, 2'b00);
    axi_write("w1", 5'h04, 32'd2, 4'hF, 2'b00);
    axi_write("w2", 5'h08, 32'd3, 4'hF, 2'b00);
    axi_write("w3", 5'h0C, 32'd4, 4'hF, 2'b00);
    axi_read("r0", 5'h00, 32'd1, 2'b00);
    axi_read("r1", 5'h05, 32'd2, 2'b00);
    axi_read("r2", 5'h08, 32'd3, 2'b00);
    axi_read("r3", 5'h0F, 32'd4, 2'b00);
    axi_read("cnt4", 5'h10, 32'd4, 2'b00);
    check("idle.rdata", rdata, 32'd0);

    // Byte strobes
    axi_write("wbase", 5'h00, 32'h0000_0001, 4'hF, 2'b00);
    axi_write("wstrb", 5'h00, 32'hAABB_CCDD, 4'b0101, 2'b00);
    axi_read("rstrb", 5'h00, 32'h00BB_00DD, 2'b00);
    axi_write("wnostrb", 5'h04, 32'hFFFF_FFFF, 4'b0000, 2'b00);
    axi_read("rnostrb", 5'h04, 32'd2, 2'b00);
    axi_read("cnt7", 5'h10, 32'd7, 2'b00);

    // W ahead of AW by 3 cycles, slow BREADY
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge ACLK);
    wvalid = 1'b0;
    check("wfirst.wready", {31'd0, wready}, 32'd0);
    @(negedge ACLK);
    @(negedge ACLK);
    check("wfirst.nob", {31'd0, bvalid}, 32'd0);
    awaddr = 5'h0C; awvalid = 1'b1;
    @(negedge ACLK);
    awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold.bvalid", {30'd0, bvalid, awready}, 32'd2);
      @(negedge ACLK);
    end
    bready = 1'b1;
    @(negedge ACLK);
    bready = 1'b0;
    check("bdone", {29'd0, bvalid, awready, wready}, 32'd3);
    axi_read("r3late", 5'h0C, 32'h77, 2'b00);
    axi_read("cnt8", 5'h10, 32'd8, 2'b00);

    // Read-only and unmapped words
    axi_write("wcnt", 5'h10, 32'h1234, 4'hF, 2'b00);
    axi_write("wid", 5'h14, 32'h1234, 4'hF, 2'b00);
    axi_read("rid", 5'h14, 32'h0000_0100, 2'b00);
    axi_write("w6", 5'h18, 32'hDEAD, 4'hF, UNMAP_RESP);
    axi_read("r6", 5'h18, 32'd0, UNMAP_RESP);
    axi_read("r7", 5'h1C, 32'd0, UNMAP_RESP);
    axi_read("cnt8b", 5'h10, 32'd8, 2'b00);

    // Read and write commit to the same word on the same edge
    awaddr = 5'h08; awvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 5'h08; arvalid = 1'b1;
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("same.valids", {30'd0, bvalid, rvalid}, 32'd3);
    check("same.rdata", rdata, 32'd3);
    bready = 1'b1; rready = 1'b1;
    @(negedge ACLK);
    bready = 1'b0; rready = 1'b0;
    axi_read("same.after", 5'h08, 32'h55, 2'b00);
    axi_read("cnt9", 5'h10, 32'd9, 2'b00);

    // Reset while both responses are pending
    awaddr = 5'h00; awvalid = 1'b1; wdata = 32'h12; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 5'h04; arvalid = 1'b1;
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("pend.valids", {30'd0, bvalid, rvalid}, 32'd3);
    #2 ARESET = 1'b1;
    #1;
    check("arst.outs", {27'd0, bvalid, rvalid, awready, wready, arready}, 32'd0);
    check("arst.rdata", rdata, 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (3) @(negedge ACLK);
    check("post.nresp", {30'd0, bvalid, rvalid}, 32'd0);
    axi_read("post.r0", 5'h00, 32'd0, 2'b00);
    axi_read("post.r2", 5'h08, 32'd0, 2'b00);
    axi_read("post.cnt", 5'h10, 32'd0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
